// File: rtl/nbit_mult_pkg.sv
// Shared types and helpers for the nbit_mult_add shift-add multiply-accumulate block.
package nbit_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/nbit_mult_add.sv
// Sequential unsigned multiply-accumulate: product = multiplicand * multiplier + addend.
// Define NBIT_MULT_EARLY_EXIT_EN to leave CALC once the remaining multiplier bits are zero.
module nbit_mult_add
    import nbit_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;

    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    // w_last flags that the step taken on this edge is the final one.
    always_comb begin
`ifdef NBIT_MULT_EARLY_EXIT_EN
        w_last = ((r_mplier >> 1) == '0) || (r_cnt == CNT_W'(WIDTH - 1));
`else
        w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Addend seeds the accumulator so no final add step is needed.
                        r_acc    <= {{WIDTH{1'b0}}, addend};
                        r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
                        r_mplier <= multiplier;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign product = r_acc;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: doc/nbit_mult_add.md
NBIT_MULT_ADD -- requirements
Module: nbit_mult_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port multiplicand, input, WIDTH bits: unsigned operand A (divisor-side value).
REQ-006 The block SHALL have port multiplier, input, WIDTH bits: unsigned operand B (quotient-side value).
REQ-007 The block SHALL have port addend, input, WIDTH bits: unsigned operand C (remainder-side value).
REQ-008 The block SHALL have port product, output, 2*WIDTH bits: result A*B+C.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (CALC or DONE).
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking product valid.

Function
REQ-011 The block SHALL compute product = multiplicand*multiplier + addend, unsigned; the result always fits in 2*WIDTH bits (max 2^(2W)-2^W), so no overflow or saturation logic exists.
REQ-012 The FSM SHALL have states IDLE, CALC, DONE: IDLE->CALC on start=1; CALC->DONE after the last iteration; DONE->IDLE unconditionally after one cycle.
REQ-013 The block SHALL capture all three operands at the edge E0 that samples start=1 in IDLE; later operand changes SHALL NOT affect the result.
REQ-014 CALC SHALL perform one shift-add step per cycle, processing multiplier LSB first, for exactly WIDTH cycles; DONE SHALL be entered at edge E0+WIDTH.
REQ-015 done SHALL be 1 exactly for the cycle in DONE (E0+WIDTH to E0+WIDTH+1), and 0 otherwise.
REQ-016 product SHALL be valid from entry to DONE and held unchanged until the next accepted start; its value during CALC is unspecified.
REQ-017 busy SHALL be 1 from E0 until DONE->IDLE, and 0 in IDLE.
REQ-018 start SHALL be ignored in CALC and DONE; a start held high through DONE SHALL be accepted at the first edge in IDLE, giving back-to-back operations two edges apart at the DONE/IDLE boundary.
REQ-019 Zero operands (A=0, B=0 or C=0) SHALL need no special casing and SHALL take the same latency as any other value, unless the option in REQ-023 is compiled in.

Reset
REQ-020 On rstn=0, asynchronously: state=IDLE, product=0, busy=0, done=0, internal accumulator and counters=0.
REQ-021 A reset during CALC or DONE SHALL abort the operation with no done pulse; after rstn rises, the first start is accepted normally.

Configuration
REQ-022 Macro NBIT_MULT_EARLY_EXIT_EN SHALL control early termination.
REQ-023 With NBIT_MULT_EARLY_EXIT_EN defined, CALC SHALL exit to DONE on the edge where the unprocessed multiplier bits are all zero; DONE is then entered at E0+max(1,k), where k is the index+1 of the highest set bit of B. B=0 SHALL give DONE at E0+1. The product value SHALL be identical to that without the macro.
REQ-024 Without the macro, latency SHALL be fixed at WIDTH per REQ-014.

Structure
REQ-025 Package nbit_mult_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and a function giving the counter width, $clog2(WIDTH+1).
REQ-026 The block SHALL be a single module; no sub-module is warranted. Datapath: 2*WIDTH accumulator, WIDTH shift register, iteration counter.

Verification
REQ-027 WIDTH=2, exhaustive A, B, C in 0..3: for each, pulse start, wait for done, then check product==A*B+C; 64 checks pass. This includes quotient*divisor+remainder reconstruction for every legal divider result.
REQ-028 WIDTH=8, A=255, B=255, C=255 -> product=16'hFF00, done exactly 8 edges after E0 (macro off).
REQ-029 WIDTH=8, start held high continuously with A=3, B=5, C=1 -> product=16 on every done; the next busy rise occurs on the edge after DONE->IDLE; operands changed mid-CALC do not alter the result.
REQ-030 WIDTH=8, rstn pulsed low 3 cycles into CALC -> product=0, busy=0, done=0 immediately and no done pulse; a new start with A=7, B=6, C=0 -> product=42.
REQ-031 WIDTH=8 with NBIT_MULT_EARLY_EXIT_EN defined: B=0, A=9, C=4 -> product=4, done at E0+1; B=8'h05, A=10, C=0 -> product=50, done at E0+3.
